// File: rtl/mem_req_arbiter_if.sv
// Bundle between the two client ports (instruction fetch A, data B) and the memory controller.
// slave: the arbiter's view; master: the view of whoever drives the clients and the controller.
interface mem_req_arbiter_if;
  logic        a_req;
  logic [15:0] a_addr;
  logic [15:0] a_rdata;
  logic        a_ack;
  logic        b_req;
  logic        b_we;
  logic [15:0] b_addr;
  logic [15:0] b_wdata;
  logic [15:0] b_rdata;
  logic        b_ack;
  logic        request;
  logic        request_type;
  logic [15:0] request_address;
  logic [15:0] data_out;
  logic [15:0] data_in;
  logic        memory_ready;
  logic        write_complete;
  logic        timeout_err;

  modport slave (
    input  a_req, a_addr, b_req, b_we, b_addr, b_wdata,
    input  data_in, memory_ready, write_complete,
    output a_rdata, a_ack, b_rdata, b_ack,
    output request, request_type, request_address, data_out, timeout_err
  );

  modport master (
    output a_req, a_addr, b_req, b_we, b_addr, b_wdata,
    output data_in, memory_ready, write_complete,
    input  a_rdata, a_ack, b_rdata, b_ack,
    input  request, request_type, request_address, data_out, timeout_err
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter of two request ports onto one single-outstanding memory controller.
// Latency: req in IDLE T -> request T+1 -> WAIT; completion C -> ack C+1 -> IDLE C+2; clients hold req until ack.
module mem_req_arbiter #(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd200
) (
  input  logic              clk,
  input  logic              reset,
  mem_req_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state_q;
  logic [7:0]  wait_cnt_q;
  logic        last_b_q;
  logic        grant_b_q;
  logic        request_q;
  logic        req_type_q;
  logic [15:0] req_addr_q;
  logic [15:0] data_out_q;
  logic        a_ack_q;
  logic        b_ack_q;
  logic [15:0] a_rdata_q;
  logic [15:0] b_rdata_q;
  logic        timeout_q;

  logic grant_a_d;
  logic grant_b_d;
  logic rd_done_d;
  logic done_d;
  logic timeout_d;

  always_comb begin
    grant_a_d = bus.a_req && (!bus.b_req || last_b_q);
    grant_b_d = bus.b_req && !grant_a_d;
    // Only the completion pulse matching the transaction type counts.
    rd_done_d = !req_type_q && bus.memory_ready;
    done_d    = rd_done_d || (req_type_q && bus.write_complete);
    timeout_d = (wait_cnt_q == TIMEOUT_CYCLES - 8'd1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= 8'd0;
      last_b_q   <= 1'b1;
      grant_b_q  <= 1'b0;
      request_q  <= 1'b0;
      req_type_q <= 1'b0;
      req_addr_q <= 16'd0;
      data_out_q <= 16'd0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      a_rdata_q  <= 16'd0;
      b_rdata_q  <= 16'd0;
      timeout_q  <= 1'b0;
    end else begin
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      request_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_a_d || grant_b_d) begin
            grant_b_q  <= grant_b_d;
            last_b_q   <= grant_b_d;
            req_addr_q <= grant_b_d ? bus.b_addr : bus.a_addr;
            req_type_q <= grant_b_d && bus.b_we;
            if (grant_b_d) data_out_q <= bus.b_wdata;
            request_q  <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt_q <= 8'd0;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (done_d) begin
            if (rd_done_d) begin
              if (grant_b_q) b_rdata_q <= bus.data_in;
              else           a_rdata_q <= bus.data_in;
            end
            a_ack_q <= !grant_b_q;
            b_ack_q <= grant_b_q;
            state_q <= DONE;
          end else if (timeout_d) begin
            // Abandon: a timed-out read returns all-ones so the client sees poisoned data.
            timeout_q <= 1'b1;
            if (!req_type_q) begin
              if (grant_b_q) b_rdata_q <= 16'hFFFF;
              else           a_rdata_q <= 16'hFFFF;
            end
            a_ack_q <= !grant_b_q;
            b_ack_q <= grant_b_q;
            state_q <= DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.a_rdata         = a_rdata_q;
  assign bus.a_ack           = a_ack_q;
  assign bus.b_rdata         = b_rdata_q;
  assign bus.b_ack           = b_ack_q;
  assign bus.request         = request_q;
  assign bus.request_type    = req_type_q;
  assign bus.request_address = req_addr_q;
  assign bus.data_out        = data_out_q;
  assign bus.timeout_err     = timeout_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: scenario tasks drive the ports and the memory controller side,
// expected grants/data are queued when a request is driven and popped when the DUT answers.
module tb_mem_req_arbiter;

  logic clk;
  logic reset;
  mem_req_arbiter_if bus();

  mem_req_arbiter #(.TIMEOUT_CYCLES(8'd200)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic        port_b;
    logic [15:0] addr;
    logic [15:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (bus.request !== 1'b1 && cyc < 50);
  endtask

  task automatic wait_ack(input int bound, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (bus.a_ack !== 1'b1 && bus.b_ack !== 1'b1 && cyc < bound);
  endtask

  task automatic idle_inputs();
    bus.a_req = 0; bus.a_addr = 0; bus.b_req = 0; bus.b_we = 0;
    bus.b_addr = 0; bus.b_wdata = 0; bus.data_in = 0;
    bus.memory_ready = 0; bus.write_complete = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    n_cmp++; if (bus.request !== 1'b0) begin n_err++; $display("FAIL reset_request: got %b want 0", bus.request); end
    n_cmp++; if ({bus.request_type, bus.request_address, bus.data_out} !== 33'd0) begin n_err++; $display("FAIL reset_req_bus: got %h want 0", {bus.request_type, bus.request_address, bus.data_out}); end
    n_cmp++; if ({bus.a_ack, bus.b_ack, bus.timeout_err} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {bus.a_ack, bus.b_ack, bus.timeout_err}); end
    n_cmp++; if ({bus.a_rdata, bus.b_rdata} !== 32'd0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", {bus.a_rdata, bus.b_rdata}); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_a_read();
    exp_t e;
    bus.a_addr = 16'h1234; bus.a_req = 1'b1;
    sb_q.push_back('{port_b: 1'b0, addr: 16'h1234, rdata: 16'hBEEF});
    tick();
    e = sb_q.pop_front();
    n_cmp++; if ({bus.request, bus.request_type, bus.request_address} !== {1'b1, 1'b0, e.addr}) begin n_err++; $display("FAIL a_read_issue: got %b %b %h want 1 0 %h", bus.request, bus.request_type, bus.request_address, e.addr); end
    tick();
    n_cmp++; if (bus.request !== 1'b0) begin n_err++; $display("FAIL a_read_request_pulse: got %b want 0", bus.request); end
    repeat (5) tick();
    bus.memory_ready = 1'b1; bus.data_in = 16'hBEEF;
    tick();
    bus.memory_ready = 1'b0; bus.data_in = 16'h0; bus.a_req = 1'b0;
    n_cmp++; if ({bus.a_ack, bus.b_ack} !== 2'b10) begin n_err++; $display("FAIL a_read_ack: got %b want 10", {bus.a_ack, bus.b_ack}); end
    n_cmp++; if (bus.a_rdata !== e.rdata) begin n_err++; $display("FAIL a_read_rdata: got %h want %h", bus.a_rdata, e.rdata); end
    tick();
    n_cmp++; if (bus.a_ack !== 1'b0) begin n_err++; $display("FAIL a_read_ack_width: got %b want 0", bus.a_ack); end
    n_cmp++; if (bus.b_rdata !== 16'h0) begin n_err++; $display("FAIL a_read_b_rdata_untouched: got %h want 0", bus.b_rdata); end
  endtask

  task automatic test_b_write();
    exp_t e;
    int   cyc;
    bus.b_we = 1'b1; bus.b_addr = 16'h0100; bus.b_wdata = 16'hA5A5; bus.b_req = 1'b1;
    sb_q.push_back('{port_b: 1'b1, addr: 16'h0100, rdata: 16'h0});
    wait_req(cyc);
    e = sb_q.pop_front();
    n_cmp++; if ({bus.request, bus.request_type, bus.request_address, bus.data_out} !== {1'b1, 1'b1, e.addr, 16'hA5A5}) begin n_err++; $display("FAIL b_write_issue: got %b %b %h %h want 1 1 %h a5a5", bus.request, bus.request_type, bus.request_address, bus.data_out, e.addr); end
    tick();
    bus.memory_ready = 1'b1; bus.data_in = 16'h5555;
    tick();
    bus.memory_ready = 1'b0; bus.data_in = 16'h0;
    n_cmp++; if ({bus.a_ack, bus.b_ack} !== 2'b00) begin n_err++; $display("FAIL b_write_ignore_ready: got %b want 00", {bus.a_ack, bus.b_ack}); end
    tick(); tick();
    n_cmp++; if ({bus.request_type, bus.data_out, bus.b_ack} !== {1'b1, 16'hA5A5, 1'b0}) begin n_err++; $display("FAIL b_write_hold: got %b %h %b want 1 a5a5 0", bus.request_type, bus.data_out, bus.b_ack); end
    bus.write_complete = 1'b1;
    tick();
    bus.write_complete = 1'b0; bus.b_req = 1'b0;
    n_cmp++; if ({bus.a_ack, bus.b_ack} !== 2'b01) begin n_err++; $display("FAIL b_write_ack: got %b want 01", {bus.a_ack, bus.b_ack}); end
    n_cmp++; if ({bus.a_rdata, bus.b_rdata} !== {16'hBEEF, e.rdata}) begin n_err++; $display("FAIL b_write_rdata_untouched: got %h want %h", {bus.a_rdata, bus.b_rdata}, {16'hBEEF, e.rdata}); end
    tick();
    n_cmp++; if ({bus.b_ack, bus.data_out, bus.request_type} !== {1'b0, 16'hA5A5, 1'b1}) begin n_err++; $display("FAIL b_write_after: got %b %h %b want 0 a5a5 1", bus.b_ack, bus.data_out, bus.request_type); end
  endtask

  // Both ports held high from reset; also checks the next request comes only after the post-DONE IDLE cycle.
  task automatic test_round_robin();
    exp_t e;
    int   cyc;
    reset = 1'b1; tick(); reset = 1'b0;
    bus.a_addr = 16'h1111; bus.b_addr = 16'h2222; bus.b_we = 1'b1; bus.b_wdata = 16'h5A5A;
    for (int k = 0; k < 4; k++)
      sb_q.push_back('{port_b: k[0], addr: k[0] ? 16'h2222 : 16'h1111, rdata: 16'h1000 + 16'(k)});
    bus.a_req = 1'b1; bus.b_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_req(cyc);
      e = sb_q.pop_front();
      n_cmp++; if (bus.request_address !== e.addr) begin n_err++; $display("FAIL rr_grant_%0d: got %h want %h", k, bus.request_address, e.addr); end
      if (k > 0) begin
        n_cmp++; if (cyc !== 1) begin n_err++; $display("FAIL rr_regrant_delay_%0d: got %0d want 1", k, cyc); end
      end
      tick();
      if (bus.request_type) bus.write_complete = 1'b1;
      else begin bus.memory_ready = 1'b1; bus.data_in = e.rdata; end
      tick();
      bus.write_complete = 1'b0; bus.memory_ready = 1'b0; bus.data_in = 16'h0;
      n_cmp++; if ({bus.a_ack, bus.b_ack, bus.request} !== {!e.port_b, e.port_b, 1'b0}) begin n_err++; $display("FAIL rr_ack_%0d: got %b want %b", k, {bus.a_ack, bus.b_ack, bus.request}, {!e.port_b, e.port_b, 1'b0}); end
      if (!e.port_b) begin
        n_cmp++; if (bus.a_rdata !== e.rdata) begin n_err++; $display("FAIL rr_rdata_%0d: got %h want %h", k, bus.a_rdata, e.rdata); end
      end
      tick();
      n_cmp++; if (bus.request !== 1'b0) begin n_err++; $display("FAIL rr_idle_no_request_%0d: got %b want 0", k, bus.request); end
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_timeout();
    exp_t e;
    int   cyc;
    bus.b_we = 1'b0; bus.b_addr = 16'h0200; bus.b_req = 1'b1;
    sb_q.push_back('{port_b: 1'b1, addr: 16'h0200, rdata: 16'hFFFF});
    wait_req(cyc);
    e = sb_q.pop_front();
    n_cmp++; if ({bus.request, bus.request_address} !== {1'b1, e.addr}) begin n_err++; $display("FAIL to_issue: got %b %h want 1 %h", bus.request, bus.request_address, e.addr); end
    wait_ack(400, cyc);
    bus.b_req = 1'b0;
    n_cmp++; if (cyc !== 201) begin n_err++; $display("FAIL to_latency: got %0d want 201", cyc); end
    n_cmp++; if ({bus.a_ack, bus.b_ack, bus.timeout_err} !== 3'b011) begin n_err++; $display("FAIL to_ack_flag: got %b want 011", {bus.a_ack, bus.b_ack, bus.timeout_err}); end
    n_cmp++; if (bus.b_rdata !== e.rdata) begin n_err++; $display("FAIL to_rdata: got %h want %h", bus.b_rdata, e.rdata); end
    repeat (3) tick();
    n_cmp++; if ({bus.timeout_err, bus.b_rdata} !== {1'b1, 16'hFFFF}) begin n_err++; $display("FAIL to_sticky: got %b %h want 1 ffff", bus.timeout_err, bus.b_rdata); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   cyc;
    bit   saw_ack;
    bus.a_addr = 16'h4321; bus.a_req = 1'b1;
    wait_req(cyc);
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({bus.request, bus.request_type, bus.request_address, bus.data_out} !== 34'd0) begin n_err++; $display("FAIL rst_mid_req_bus: got %h want 0", {bus.request, bus.request_type, bus.request_address, bus.data_out}); end
    n_cmp++; if ({bus.a_ack, bus.b_ack, bus.timeout_err, bus.a_rdata, bus.b_rdata} !== 35'd0) begin n_err++; $display("FAIL rst_mid_outputs: got %h want 0", {bus.a_ack, bus.b_ack, bus.timeout_err, bus.a_rdata, bus.b_rdata}); end
    bus.a_req = 1'b0; bus.memory_ready = 1'b1; bus.data_in = 16'hDEAD;
    tick();
    reset = 1'b0;
    tick();
    bus.memory_ready = 1'b0; bus.data_in = 16'h0;
    saw_ack = 1'b0;
    repeat (3) begin
      tick();
      if (bus.a_ack === 1'b1 || bus.b_ack === 1'b1) saw_ack = 1'b1;
    end
    n_cmp++; if ({saw_ack, bus.a_rdata} !== {1'b0, 16'h0}) begin n_err++; $display("FAIL rst_mid_no_ack: got %b %h want 0 0000", saw_ack, bus.a_rdata); end
    bus.a_addr = 16'h0042; bus.a_req = 1'b1;
    sb_q.push_back('{port_b: 1'b0, addr: 16'h0042, rdata: 16'h7777});
    wait_req(cyc);
    e = sb_q.pop_front();
    n_cmp++; if ({cyc, bus.request_address} !== {32'd1, e.addr}) begin n_err++; $display("FAIL rst_mid_regrant: got %0d %h want 1 %h", cyc, bus.request_address, e.addr); end
    tick();
    bus.memory_ready = 1'b1; bus.data_in = e.rdata;
    tick();
    bus.memory_ready = 1'b0; bus.data_in = 16'h0; bus.a_req = 1'b0;
    n_cmp++; if ({bus.a_ack, bus.a_rdata} !== {1'b1, e.rdata}) begin n_err++; $display("FAIL rst_mid_complete: got %b %h want 1 %h", bus.a_ack, bus.a_rdata, e.rdata); end
    tick();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_a_read();
    test_b_write();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
